// File: rtl/instruction_memory_pkg.sv
// instruction_memory_pkg: shared states, requester ids and sizing constants for instruction memory sequencing
package instruction_memory_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
    typedef enum logic {FETCH, LOAD} requester_t;
    localparam int WORD_INDEX_WIDTH = 10;
    localparam int BYTE_ADDRESS_LIMIT = 4096;
endpackage

// File: rtl/instruction_memory_arbiter_latency_counter.sv
// latency_counter: loadable saturating down-counter; done marks the final counted cycle (count == 1)
module latency_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic [WIDTH-1:0] count,
    output logic             done
);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (load) count <= load_value;
        else if (decrement && count != '0) count <= count - WIDTH'(1);
    end
    assign done = count == WIDTH'(1);
endmodule

// File: rtl/instruction_memory_arbiter.sv
// instruction_memory_arbiter: shares the single-port instruction memory between fetch and loader requesters
module instruction_memory_arbiter
    import instruction_memory_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int MEM_WORDS    = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    output logic        fetch_accept,
    output logic        fetch_valid,
    output logic [31:0] fetch_instruction,
    output logic        fetch_error,
    input  logic        load_request,
    input  logic        load_write,
    input  logic [31:0] load_address,
    input  logic [31:0] load_write_data,
    output logic        load_accept,
    output logic        load_valid,
    output logic [31:0] load_read_data,
    output logic        load_error,
    output logic [9:0]  mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        busy
);
    localparam int CW = 4;
    state_t state, next_state;
    requester_t grant, last_grant;
    logic write_q, error_q, grant_fetch, take, bad_address, count_done;
    logic [31:0] address;
    logic [CW-1:0] count;
    // Ties go to whoever was not served last; last_grant resets to LOAD so fetch wins the first tie.
    assign grant_fetch = fetch_request && (!load_request || last_grant == LOAD);
    assign take = state == IDLE && (fetch_request || load_request);
    assign address = grant_fetch ? fetch_address : load_address;
    assign bad_address = address[1:0] != 2'b00 || address >= 32'(4 * MEM_WORDS);
    latency_counter #(.WIDTH(CW)) counter (
        .clock(clock),
        .reset_n(reset_n),
        .load(mem_read_enable),
        .load_value(CW'(READ_LATENCY)),
        .decrement(state == WAIT),
        .count(count),
        .done(count_done)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = take ? ISSUE : IDLE;
            ISSUE:   next_state = (write_q || error_q) ? RESPOND : WAIT;
            WAIT:    next_state = count_done ? RESPOND : WAIT;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        fetch_accept = take && grant_fetch;
        load_accept = take && !grant_fetch;
        mem_read_enable = state == ISSUE && !write_q && !error_q;
        mem_write_enable = state == ISSUE && write_q && !error_q;
        fetch_valid = state == RESPOND && grant == FETCH;
        load_valid = state == RESPOND && grant == LOAD;
        fetch_error = fetch_valid && error_q;
        load_error = load_valid && error_q;
        busy = state != IDLE;
    end
    // Memory-side address/data only move when a strobe will follow; responses load just before RESPOND.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant <= FETCH;
            last_grant <= LOAD;
            write_q <= 1'b0;
            error_q <= 1'b0;
            mem_address <= '0;
            mem_write_data <= '0;
            fetch_instruction <= '0;
            load_read_data <= '0;
        end else begin
            if (take) begin
                grant <= grant_fetch ? FETCH : LOAD;
                last_grant <= grant_fetch ? FETCH : LOAD;
                write_q <= !grant_fetch && load_write;
                error_q <= bad_address;
                if (!bad_address) mem_address <= address[WORD_INDEX_WIDTH+1:2];
                if (!bad_address && !grant_fetch && load_write) mem_write_data <= load_write_data;
            end
            if (state == ISSUE && error_q) begin
                if (grant == FETCH) fetch_instruction <= '0;
                else load_read_data <= '0;
            end
            if (state == WAIT && count_done) begin
                if (grant == FETCH) fetch_instruction <= mem_read_data;
                else load_read_data <= mem_read_data;
            end
        end
    end
endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// tb_instruction_memory_arbiter: directed vector bench for the arbiter at READ_LATENCY 2 and 5
module tb_instruction_memory_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;
    logic        fetch_request = 1'b0, load_request = 1'b0, load_write = 1'b0;
    logic [31:0] fetch_address = '0, load_address = '0, load_write_data = '0;
    logic        fetch_accept, fetch_valid, fetch_error, load_accept, load_valid, load_error;
    logic [31:0] fetch_instruction, load_read_data, mem_write_data, mem_read_data;
    logic [9:0]  mem_address;
    logic        mem_read_enable, mem_write_enable, busy;
    logic        l5_fetch_request = 1'b0;
    logic [31:0] l5_fetch_address = '0;
    logic        l5_fetch_accept, l5_fetch_valid, l5_fetch_error, l5_load_accept, l5_load_valid, l5_load_error;
    logic [31:0] l5_fetch_instruction, l5_load_read_data, l5_mem_write_data, l5_mem_read_data;
    logic [9:0]  l5_mem_address;
    logic        l5_mem_read_enable, l5_mem_write_enable, l5_busy;
    instruction_memory_arbiter #(.READ_LATENCY(2), .MEM_WORDS(1024)) dut (
        .clock(clock), .reset_n(reset_n),
        .fetch_request(fetch_request), .fetch_address(fetch_address), .fetch_accept(fetch_accept),
        .fetch_valid(fetch_valid), .fetch_instruction(fetch_instruction), .fetch_error(fetch_error),
        .load_request(load_request), .load_write(load_write), .load_address(load_address),
        .load_write_data(load_write_data), .load_accept(load_accept), .load_valid(load_valid),
        .load_read_data(load_read_data), .load_error(load_error),
        .mem_address(mem_address), .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
    );
    instruction_memory_arbiter #(.READ_LATENCY(5), .MEM_WORDS(1024)) dut5 (
        .clock(clock), .reset_n(reset_n),
        .fetch_request(l5_fetch_request), .fetch_address(l5_fetch_address), .fetch_accept(l5_fetch_accept),
        .fetch_valid(l5_fetch_valid), .fetch_instruction(l5_fetch_instruction), .fetch_error(l5_fetch_error),
        .load_request(1'b0), .load_write(1'b0), .load_address(32'h0),
        .load_write_data(32'h0), .load_accept(l5_load_accept), .load_valid(l5_load_valid),
        .load_read_data(l5_load_read_data), .load_error(l5_load_error),
        .mem_address(l5_mem_address), .mem_read_enable(l5_mem_read_enable), .mem_write_enable(l5_mem_write_enable),
        .mem_write_data(l5_mem_write_data), .mem_read_data(l5_mem_read_data), .busy(l5_busy)
    );
    logic [31:0] mem [0:1023];
    logic [31:0] pipe2 [0:1];
    logic [31:0] pipe5 [0:4];
    always @(posedge clock) begin
        if (!reset_n) mem[2] <= 32'h32100004;
        else if (mem_write_enable) mem[mem_address] <= mem_write_data;
        pipe2[0] <= mem_read_enable ? mem[mem_address] : 32'hDEADBEEF;
        pipe2[1] <= pipe2[0];
        pipe5[0] <= l5_mem_read_enable ? mem[l5_mem_address] : 32'hDEADBEEF;
        for (int i = 1; i < 5; i++) pipe5[i] <= pipe5[i-1];
    end
    assign mem_read_data = pipe2[1];
    assign l5_mem_read_data = pipe5[4];
    typedef struct {
        logic        is_load;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          strobe;
        logic [9:0]  index;
        int          valid_cycle;
        logic [31:0] data;
        logic        err;
    } vec_t;
    vec_t vecs [10];
    int vectors = 0;
    int miscompares = 0;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask
    function automatic logic [31:0] outs_or();
        return fetch_instruction | load_read_data | mem_write_data | {22'b0, mem_address} |
               {23'b0, fetch_accept, fetch_valid, fetch_error, load_accept, load_valid, load_error,
                mem_read_enable, mem_write_enable, busy};
    endfunction
    task automatic run_vec(input int n, input vec_t v);
        int strobe_count = 0, strobe_cycle = -1, strobe_kind = 0, valid_cycle = -1, other_valid = 0;
        logic [31:0] data = '0;
        logic err = 1'b0;
        logic [9:0] idx = '0;
        @(negedge clock);
        load_write = v.write;
        if (v.is_load) begin
            load_request = 1'b1;
            load_address = v.addr;
            load_write_data = v.wdata;
        end else begin
            fetch_request = 1'b1;
            fetch_address = v.addr;
        end
        #1;
        check($sformatf("v%0d accept", n), 32'(v.is_load ? load_accept : fetch_accept), 32'd1);
        @(posedge clock);
        #1;
        fetch_request = 1'b0;
        load_request = 1'b0;
        for (int c = 1; c <= 20 && valid_cycle < 0; c++) begin
            @(negedge clock);
            if (mem_read_enable || mem_write_enable) begin
                strobe_count++;
                strobe_cycle = c;
                strobe_kind = mem_read_enable ? 1 : 2;
                idx = mem_address;
            end
            if (v.is_load ? fetch_valid : load_valid) other_valid++;
            if (v.is_load ? load_valid : fetch_valid) begin
                valid_cycle = c;
                data = v.is_load ? load_read_data : fetch_instruction;
                err = v.is_load ? load_error : fetch_error;
            end
        end
        check($sformatf("v%0d strobe kind", n), 32'(strobe_kind), 32'(v.strobe));
        check($sformatf("v%0d strobe count", n), 32'(strobe_count), (v.strobe != 0) ? 32'd1 : 32'd0);
        if (v.strobe != 0) begin
            check($sformatf("v%0d strobe cycle", n), 32'(strobe_cycle), 32'd1);
            check($sformatf("v%0d mem_address", n), 32'(idx), 32'(v.index));
        end
        check($sformatf("v%0d valid cycle", n), 32'(valid_cycle), 32'(v.valid_cycle));
        check($sformatf("v%0d data", n), data, v.data);
        check($sformatf("v%0d error", n), 32'(err), 32'(v.err));
        check($sformatf("v%0d other valid", n), 32'(other_valid), 32'd0);
        @(negedge clock);
        check($sformatf("v%0d busy after", n), 32'(busy), 32'd0);
        check($sformatf("v%0d valid one cycle", n), 32'(fetch_valid || load_valid), 32'd0);
        load_write = 1'b0;
    endtask
    task automatic wait_idle(input string name);
        int c = 0;
        while (busy && c < 30) begin
            @(negedge clock);
            c++;
        end
        check({name, " idle bound"}, 32'(busy), 32'd0);
    endtask
    initial begin
        int kinds [8];
        int cycs [8];
        int n_acc, overlap, seen, valid_cycle, re_count, re_cycle;
        logic [31:0] data;
        vecs[0] = '{1'b0, 1'b0, 32'h8,    32'h0,        1, 10'd2,   4, 32'h32100004, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h10,   32'h8C110000, 2, 10'd4,   2, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h10,   32'h0,        1, 10'd4,   4, 32'h8C110000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'hFFC,  32'h12345678, 2, 10'h3FF, 2, 32'h8C110000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'hFFC,  32'h0,        1, 10'h3FF, 4, 32'h12345678, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h6,    32'h0,        0, 10'd0,   2, 32'h0,        1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h1000, 32'h0,        0, 10'd0,   2, 32'h0,        1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h3,    32'h0,        0, 10'd0,   2, 32'h0,        1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h1002, 32'hFFFFFFFF, 0, 10'd0,   2, 32'h0,        1'b1};
        vecs[9] = '{1'b0, 1'b1, 32'h10,   32'h0,        1, 10'd4,   4, 32'h8C110000, 1'b0};
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset outputs", outs_or(), 32'h0);
        reset_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (fetch_valid || load_valid || busy) seen++;
        end
        check("idle after reset", 32'(seen), 32'd0);
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
        // Both requesters held high from a fresh reset.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        fetch_request = 1'b1;
        fetch_address = 32'h8;
        load_request = 1'b1;
        load_write = 1'b0;
        load_address = 32'h10;
        #1;
        n_acc = 0;
        overlap = 0;
        for (int c = 0; c < 20; c++) begin
            if (fetch_accept || load_accept) begin
                if (n_acc < 8) begin
                    kinds[n_acc] = load_accept ? 1 : 0;
                    cycs[n_acc] = c;
                end
                n_acc++;
            end
            if ((fetch_accept && fetch_valid) || (load_accept && load_valid)) overlap++;
            @(negedge clock);
            #1;
        end
        fetch_request = 1'b0;
        load_request = 1'b0;
        check("tie accept count", 32'(n_acc), 32'd4);
        for (int i = 0; i < 4 && i < n_acc; i++) begin
            check($sformatf("tie grant %0d", i), 32'(kinds[i]), 32'(i % 2));
            check($sformatf("tie cycle %0d", i), 32'(cycs[i]), 32'(5 * i));
        end
        check("tie overlap", 32'(overlap), 32'd0);
        wait_idle("tie");
        // Reset while a read is waiting on memory latency.
        @(negedge clock);
        fetch_request = 1'b1;
        fetch_address = 32'h8;
        @(posedge clock);
        #1 fetch_request = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("wait busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset outputs", outs_or(), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (fetch_valid || busy) seen++;
        end
        check("no stale valid", 32'(seen), 32'd0);
        run_vec(10, vecs[0]);
        // READ_LATENCY 5 instance.
        @(negedge clock);
        l5_fetch_request = 1'b1;
        l5_fetch_address = 32'h8;
        #1;
        check("l5 accept", 32'(l5_fetch_accept), 32'd1);
        @(posedge clock);
        #1 l5_fetch_request = 1'b0;
        re_count = 0;
        re_cycle = -1;
        valid_cycle = -1;
        data = '0;
        for (int c = 1; c <= 20 && valid_cycle < 0; c++) begin
            @(negedge clock);
            if (l5_mem_read_enable) begin
                re_count++;
                re_cycle = c;
            end
            if (l5_fetch_valid) begin
                valid_cycle = c;
                data = l5_fetch_instruction;
            end
        end
        check("l5 read strobes", 32'(re_count), 32'd1);
        check("l5 strobe cycle", 32'(re_cycle), 32'd1);
        check("l5 valid cycle", 32'(valid_cycle), 32'd7);
        check("l5 data", data, 32'h32100004);
        @(negedge clock);
        check("l5 busy after", 32'(l5_busy), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_memory_arbiter.md
Name: instruction_memory_arbiter

Overview:
- Sequences and shares the single-port 4 KB instruction memory (1024 x 32-bit words) between two requesters: the CPU fetch unit (read-only) and the program loader (read/write).
- Converts byte addresses to word indices and rejects misaligned or out-of-range accesses.
- Waits out the memory's multi-cycle read latency and returns each result through a one-cycle valid pulse.
- Sits between the CPU fetch stage / loader and the instruction memory array.

Parameters:
READ_LATENCY, 2, cycles from the mem_read_enable cycle until mem_read_data is valid (legal range 1..15)
MEM_WORDS, 1024, memory depth in 32-bit words (byte range 0..4*MEM_WORDS-1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
fetch_request  in  1  fetch read request; held until fetch_accept
fetch_address  in  32  fetch byte address
fetch_accept  out  1  one-cycle pulse: fetch request taken
fetch_valid  out  1  one-cycle pulse: fetch_instruction/fetch_error valid
fetch_instruction  out  32  fetched word; holds until the next fetch response
fetch_error  out  1  qualifies fetch_valid: bad address
load_request  in  1  loader request; held until load_accept
load_write  in  1  1 = write, 0 = read
load_address  in  32  loader byte address
load_write_data  in  32  loader write data
load_accept  out  1  one-cycle pulse: loader request taken
load_valid  out  1  one-cycle pulse: loader response
load_read_data  out  32  read data; holds until the next loader read response
load_error  out  1  qualifies load_valid
mem_address  out  10  word index to memory
mem_read_enable  out  1  one-cycle read strobe
mem_write_enable  out  1  one-cycle write strobe
mem_write_data  out  32  write data to memory
mem_read_data  in  32  memory read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0, state IDLE, latency counter 0, last_grant = LOAD.
  - Any in-flight transaction is dropped. No valid pulse follows reset release.
- States: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE. Writes and errors skip WAIT.
- IDLE arbitration (combinational):
  - Only one requester high: grant it.
  - Both high: grant the requester that is not last_grant, so the first tie after reset goes to fetch.
  - Accept pulse is asserted in the IDLE cycle (cycle 0). Address, write flag and data are captured at that edge, and last_grant is updated.
- Address check at capture:
  - Error if address[1:0] != 0 or address >= 4*MEM_WORDS.
  - Word index = address[11:2].
- ISSUE (cycle 1):
  - Valid read: mem_read_enable = 1, mem_address = index, counter loaded with READ_LATENCY.
  - Valid write: mem_write_enable = 1, mem_write_data = captured data.
  - Error: no strobe.
  - Strobes are high for exactly this one cycle.
- WAIT: counter decrements each cycle. mem_read_data is sampled in cycle 1+READ_LATENCY and registered into the response data.
- RESPOND:
  - Read: valid pulse in cycle 2+READ_LATENCY.
  - Write or error: valid pulse in cycle 2.
  - Error response: error = 1, data output forced to 0.
  - Write response: load_read_data is not modified.
  - The grantee's valid/error pulse exactly one cycle. The other requester's outputs stay 0.
- Throughput:
  - Earliest next accept is the cycle after RESPOND.
  - Read occupancy is READ_LATENCY+3 cycles; write occupancy is 3 cycles.
- A request arriving while busy waits. A request dropped before accept is never served.
- mem_address and mem_write_data are held at their last values when not strobed; only the strobes are meaningful.
- The fetch side never writes: load_write is ignored on the fetch path.

Decomposition:
- Package instruction_memory_pkg:
  - State enum: IDLE, ISSUE, WAIT, RESPOND.
  - Requester enum: FETCH, LOAD.
  - Constants: WORD_INDEX_WIDTH = 10, BYTE_ADDRESS_LIMIT = 4096.
- Sub-module latency_counter: loadable down-counter with a done flag, parameterised by width. It is reused by later multi-cycle data-memory sequencing.

Test Plan:
- Reset, then fetch_request with address 0x8 (memory word 2 = 0x32100004) -> fetch_accept in cycle 0, mem_read_enable with mem_address = 2 in cycle 1, fetch_valid with 0x32100004 in cycle 4, busy low in cycle 5.
- Loader write 0x8C110000 to address 0x10, then loader read of 0x10 -> mem_write_enable with mem_address = 4 and load_valid at cycle 2; the read returns load_read_data = 0x8C110000 with load_error = 0.
- Fetch of 0x6 and of 0x1000 -> no mem strobe; fetch_valid with fetch_error = 1 and fetch_instruction = 0 at cycle 2 for each.
- Both requests held high continuously -> grants alternate FETCH, LOAD, FETCH, LOAD; no valid pulse ever overlaps an accept of the same requester.
- reset_n pulled low in WAIT of a read -> all outputs 0 immediately; after release no fetch_valid appears, and a new fetch completes normally.
- READ_LATENCY = 5 build -> fetch_valid in cycle 7; mem_read_enable high for exactly one cycle.
